// File: rtl/and_gate_pkg.sv
// Shared defaults and helpers for the and_gate block: parameter defaults
// and a width-generic saturating increment.
package and_gate_pkg;

   localparam int DEF_WIDTH = 1;
   localparam int DEF_CNT_W = 16;

   // Counters narrower than 32 bits are zero-extended into v, and the
   // result is truncated back to their width. Such a counter stops at
   // 2^w-1 and never wraps.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] max_v;
      if (w >= 32) begin
         max_v = '1;
      end else begin
         max_v = (32'd1 << w) - 32'd1;
      end
      if (v >= max_v) begin
         return max_v;
      end
      return v + 32'd1;
   endfunction

endpackage

// File: rtl/and_gate_if.sv
// Operand/result bundle for and_gate. The master drives the operands and
// the slave (the gate) returns the combinational and registered results.
interface and_gate_if #(
   parameter int WIDTH = and_gate_pkg::DEF_WIDTH,
   parameter int CNT_W = and_gate_pkg::DEF_CNT_W
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] Y_q;
   logic [WIDTH-1:0] y_rise;
   logic [WIDTH-1:0] y_fall;
   logic [CNT_W-1:0] hi_cnt;

   modport master (
      output A,
      output B,
      input  Y,
      input  Y_q,
      input  y_rise,
      input  y_fall,
      input  hi_cnt
   );

   modport slave (
      input  A,
      input  B,
      output Y,
      output Y_q,
      output y_rise,
      output y_fall,
      output hi_cnt
   );
endinterface

// File: rtl/and_gate_edge_detect.sv
// Registers a vector and flags per-bit 0->1 and 1->0 transitions. The
// flags are registered, so they line up with the new value of q.
module edge_detect #(
   parameter int WIDTH = and_gate_pkg::DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] rise_d;
   logic [WIDTH-1:0] fall_q;
   logic [WIDTH-1:0] fall_d;

   // Edges are judged against the pre-update q_q, one bit at a time.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         always_comb begin
            q_d[gi]    = d[gi];
            rise_d[gi] = d[gi] & ~q_q[gi];
            fall_d[gi] = ~d[gi] & q_q[gi];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_q    <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         q_q    <= q_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign q    = q_q;
   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/and_gate.sv
// Bitwise AND with a zero-latency output plus a registered monitor path:
// delayed copy, per-bit edge pulses and a saturating all-ones cycle count.
module and_gate
   import and_gate_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W   // at most 32 (sat_inc works on 32 bits)
) (
   input  logic         clk,
   input  logic         rst_n,
   and_gate_if.slave    bus
);

   logic [WIDTH-1:0] y;
   logic [CNT_W-1:0] hi_cnt_q;
   logic [CNT_W-1:0] hi_cnt_d;

   // Purely combinational and untouched by reset; X/Z follow 4-state AND.
   assign y     = bus.A & bus.B;
   assign bus.Y = y;

   always_comb begin
      hi_cnt_d = hi_cnt_q;
      if (&y) begin
         hi_cnt_d = CNT_W'(sat_inc(32'(hi_cnt_q), CNT_W));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hi_cnt_q <= '0;
      end else begin
         hi_cnt_q <= hi_cnt_d;
      end
   end

   assign bus.hi_cnt = hi_cnt_q;

   edge_detect #(
      .WIDTH (WIDTH)
   ) u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (y),
      .q     (bus.Y_q),
      .rise  (bus.y_rise),
      .fall  (bus.y_fall)
   );

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: three instances (1-bit, 1-bit with a
// 3-bit counter, 4-bit) compared against an integer-level reference model.
`timescale 1ns/1ps
module tb_and_gate;

   logic clk;
   logic clk_en;
   logic rst_n;
   logic       a1, b1;
   logic [3:0] a4, b4;

   int n_cmp;
   int n_bad;

   and_gate_if #(.WIDTH(1), .CNT_W(16)) if1 ();
   and_gate_if #(.WIDTH(1), .CNT_W(3))  if_s ();
   and_gate_if #(.WIDTH(4), .CNT_W(16)) if4 ();

   assign if1.A  = a1;
   assign if1.B  = b1;
   assign if_s.A = a1;
   assign if_s.B = b1;
   assign if4.A  = a4;
   assign if4.B  = b4;

   and_gate #(.WIDTH(1), .CNT_W(16)) dut1   (.clk(clk), .rst_n(rst_n), .bus(if1));
   and_gate #(.WIDTH(1), .CNT_W(3))  dut_s  (.clk(clk), .rst_n(rst_n), .bus(if_s));
   and_gate #(.WIDTH(4), .CNT_W(16)) dut4   (.clk(clk), .rst_n(rst_n), .bus(if4));

   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   // Reference model: expected registered outputs as plain integers,
   // updated from the operand values present at each rising edge.
   int m_yq1, m_r1, m_f1, m_c1, m_cs;
   int m_yq4, m_r4, m_f4, m_c4;
   always @(posedge clk) begin
      int y1, y4;
      if (!rst_n) begin
         m_yq1 = 0; m_r1 = 0; m_f1 = 0; m_c1 = 0; m_cs = 0;
         m_yq4 = 0; m_r4 = 0; m_f4 = 0; m_c4 = 0;
      end else begin
         y1 = (a1 === 1'b1 && b1 === 1'b1) ? 1 : 0;
         m_r1  = (y1 == 1 && m_yq1 == 0) ? 1 : 0;
         m_f1  = (y1 == 0 && m_yq1 == 1) ? 1 : 0;
         m_yq1 = y1;
         if (y1 == 1) begin
            if (m_c1 < 65535) m_c1 = m_c1 + 1;
            if (m_cs < 7)     m_cs = m_cs + 1;
         end
         y4 = 0;
         for (int i = 0; i < 4; i++) begin
            if (a4[i] === 1'b1 && b4[i] === 1'b1) y4 = y4 + (1 << i);
         end
         m_r4  = y4 & ~m_yq4 & 15;
         m_f4  = ~y4 & m_yq4 & 15;
         m_yq4 = y4;
         if (y4 == 15 && m_c4 < 65535) m_c4 = m_c4 + 1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_truth_table();
      logic [1:0] ab_tab [4];
      logic       y_tab  [4];
      ab_tab = '{2'b00, 2'b10, 2'b01, 2'b11};
      y_tab  = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         a1 = ab_tab[i][1];
         b1 = ab_tab[i][0];
         #5;
         n_cmp++;
         if (if1.Y !== y_tab[i]) begin
            n_bad++;
            $display("FAIL truth_table A=%b B=%b: Y got %b want %b", a1, b1, if1.Y, y_tab[i]);
         end
         $display("truth A=%b B=%b Y=%b", a1, b1, if1.Y);
      end
   endtask

   task automatic test_reset();
      clk_en = 1'b1;
      rst_n  = 1'b0;
      a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
      tick();
      tick();
      n_cmp++;
      if (if1.Y_q !== 1'b0 || if1.y_rise !== 1'b0 || if1.y_fall !== 1'b0 || if1.hi_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_state: Y_q=%b rise=%b fall=%b cnt=%0d want all 0",
                  if1.Y_q, if1.y_rise, if1.y_fall, if1.hi_cnt);
      end
      rst_n = 1'b1;
      a1 = 1'b1; b1 = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      n_cmp++;
      if (if1.hi_cnt !== 16'd3 || if1.Y_q !== 1'b1) begin
         n_bad++;
         $display("FAIL pre_reset_run: cnt=%0d Y_q=%b want 3 and 1", if1.hi_cnt, if1.Y_q);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (if1.Y !== 1'b1) begin
         n_bad++;
         $display("FAIL y_during_reset: Y got %b want 1", if1.Y);
      end
      tick();
      n_cmp++;
      if (if1.Y_q !== 1'b0 || if1.y_rise !== 1'b0 || if1.y_fall !== 1'b0 || if1.hi_cnt !== 16'd0 || if1.Y !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_reset: Y_q=%b rise=%b fall=%b cnt=%0d Y=%b want 0,0,0,0,1",
                  if1.Y_q, if1.y_rise, if1.y_fall, if1.hi_cnt, if1.Y);
      end
      $display("reset done Y_q=%b cnt=%0d", if1.Y_q, if1.hi_cnt);
      rst_n = 1'b1;
   endtask

   task automatic test_edges();
      logic b_tab[4];
      logic q_tab[4];
      logic r_tab[4];
      logic f_tab[4];
      b_tab = '{1'b0, 1'b1, 1'b1, 1'b0};
      q_tab = '{1'b0, 1'b1, 1'b1, 1'b0};
      r_tab = '{1'b0, 1'b1, 1'b0, 1'b0};
      f_tab = '{1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      a1 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b1 = b_tab[i];
         tick();
         n_cmp++;
         if (if1.Y_q !== q_tab[i] || if1.y_rise !== r_tab[i] || if1.y_fall !== f_tab[i]) begin
            n_bad++;
            $display("FAIL edges[%0d]: Y_q/rise/fall got %b%b%b want %b%b%b", i,
                     if1.Y_q, if1.y_rise, if1.y_fall, q_tab[i], r_tab[i], f_tab[i]);
         end
         $display("edge %0d B=%b Y_q=%b rise=%b fall=%b", i, b1, if1.Y_q, if1.y_rise, if1.y_fall);
      end
   endtask

   task automatic test_counter();
      do_reset();
      a1 = 1'b1; b1 = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      n_cmp++;
      if (if1.hi_cnt !== 16'd10) begin
         n_bad++;
         $display("FAIL counter_run: hi_cnt got %0d want 10", if1.hi_cnt);
      end
      b1 = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_cmp++;
      if (if1.hi_cnt !== 16'd10) begin
         n_bad++;
         $display("FAIL counter_hold: hi_cnt got %0d want 10", if1.hi_cnt);
      end
      $display("counter hi_cnt=%0d", if1.hi_cnt);
   endtask

   task automatic test_saturation();
      int want;
      do_reset();
      a1 = 1'b1; b1 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         want = (i + 1 < 7) ? i + 1 : 7;
         n_cmp++;
         if (int'(if_s.hi_cnt) != want) begin
            n_bad++;
            $display("FAIL saturation[%0d]: hi_cnt got %0d want %0d", i, if_s.hi_cnt, want);
         end
         $display("sat %0d hi_cnt=%0d", i, if_s.hi_cnt);
      end
   endtask

   task automatic test_multibit();
      do_reset();
      a4 = 4'b1100; b4 = 4'b1010;
      #1;
      n_cmp++;
      if (if4.Y !== 4'b1000) begin
         n_bad++;
         $display("FAIL multibit_y0: Y got %b want 1000", if4.Y);
      end
      tick();
      a4 = 4'b0110;
      #1;
      n_cmp++;
      if (if4.Y !== 4'b0010) begin
         n_bad++;
         $display("FAIL multibit_y1: Y got %b want 0010", if4.Y);
      end
      tick();
      n_cmp++;
      if (if4.y_rise !== 4'b0010 || if4.y_fall !== 4'b1000 || if4.Y_q !== 4'b0010) begin
         n_bad++;
         $display("FAIL multibit_edges: rise %b fall %b Y_q %b want 0010 1000 0010",
                  if4.y_rise, if4.y_fall, if4.Y_q);
      end
      $display("multibit Y_q=%b rise=%b fall=%b", if4.Y_q, if4.y_rise, if4.y_fall);
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 300; c++) begin
         // Bias towards ones so the counters and saturation get exercised.
         a1 = ($urandom_range(0, 3) != 0);
         b1 = ($urandom_range(0, 3) != 0);
         a4 = 4'($urandom) | ((c % 3 == 0) ? 4'hF : 4'h0);
         b4 = 4'($urandom) | ((c % 4 == 0) ? 4'hF : 4'h0);
         rst_n = ($urandom_range(0, 39) != 0);
         #1;
         n_cmp++;
         if (if4.Y !== (a4 & b4) || if1.Y !== (a1 & b1)) begin
            n_bad++;
            $display("FAIL rand_y[%0d]: Y1 %b Y4 %b want %b %b", c, if1.Y, if4.Y, a1 & b1, a4 & b4);
         end
         tick();
         n_cmp++;
         if (int'(if1.Y_q) != m_yq1 || int'(if1.y_rise) != m_r1 || int'(if1.y_fall) != m_f1 ||
             int'(if1.hi_cnt) != m_c1 || int'(if_s.hi_cnt) != m_cs || $isunknown(if1.Y_q)) begin
            n_bad++;
            $display("FAIL rand_w1[%0d]: q/r/f/cnt/scnt %b %b %b %0d %0d want %0d %0d %0d %0d %0d", c,
                     if1.Y_q, if1.y_rise, if1.y_fall, if1.hi_cnt, if_s.hi_cnt,
                     m_yq1, m_r1, m_f1, m_c1, m_cs);
         end
         n_cmp++;
         if (int'(if4.Y_q) != m_yq4 || int'(if4.y_rise) != m_r4 || int'(if4.y_fall) != m_f4 ||
             int'(if4.hi_cnt) != m_c4 || $isunknown(if4.Y_q)) begin
            n_bad++;
            $display("FAIL rand_w4[%0d]: q/r/f/cnt %b %b %b %0d want %0d %0d %0d %0d", c,
                     if4.Y_q, if4.y_rise, if4.y_fall, if4.hi_cnt, m_yq4, m_r4, m_f4, m_c4);
         end
         $display("rand %0d rst_n=%b A4=%h B4=%h Y_q4=%h cnt4=%0d cnt1=%0d scnt=%0d",
                  c, rst_n, a4, b4, if4.Y_q, if4.hi_cnt, if1.hi_cnt, if_s.hi_cnt);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp  = 0;
      n_bad  = 0;
      clk_en = 1'b0;
      rst_n  = 1'b0;
      a1 = 1'b0; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
      test_truth_table();
      test_reset();
      test_edges();
      test_counter();
      test_saturation();
      test_multibit();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/and_gate.md
Name: and_gate

Overview:
- Bitwise 2-input AND with a combinational output and a registered monitor path.
- Y is pure combinational A & B, with zero latency and no clock dependence.
- The clocked section adds a registered copy of Y, per-bit rise/fall event pulses, and a saturating count of cycles where Y is all-ones.
- Used as a leaf logic primitive and as a self-checking demo block in data-flow examples.

Parameters:
- WIDTH, 1, bit width of A, B, Y, Y_q, y_rise and y_fall.
- CNT_W, 16, width of the all-ones cycle counter hi_cnt.

Ports:
- clk  input  1  rising-edge clock for all sequential logic.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Y  output  WIDTH  combinational A & B.
- Y_q  output  WIDTH  Y registered by one clk cycle.
- y_rise  output  WIDTH  one-cycle pulse per bit on a 0->1 transition of Y_q.
- y_fall  output  WIDTH  one-cycle pulse per bit on a 1->0 transition of Y_q.
- hi_cnt  output  CNT_W  saturating count of cycles in which Y was all-ones.

Behaviour:
- Y = A & B, bitwise and continuous.
  - No reset effect; Y is valid whenever its inputs are valid, including during reset.
  - Any X/Z input bit propagates per standard 4-state AND (0 & X = 0, 1 & X = X).
- Truth table per bit: 00->0, 10->0, 01->0, 11->1.
- Reset: on a rising clk edge with rst_n=0, Y_q, y_rise, y_fall and hi_cnt all clear to 0.
  - Reset has priority over every other update in the same cycle.
  - Reset asserted mid-operation clears the state on the next edge, with no partial update.
- Normal edge (rst_n=1):
  - Y_q <= Y.
  - y_rise <= Y & ~Y_q and y_fall <= ~Y & Y_q. Both are computed from the pre-update Y_q and are registered, so they are valid in the same cycle as the new Y_q.
  - If Y is all-ones (&Y == 1) and hi_cnt != all-ones, hi_cnt increments by 1.
  - Otherwise hi_cnt holds. It saturates at 2^CNT_W-1 and never wraps.
- Latency: Y is 0 cycles; Y_q, y_rise and y_fall are 1 cycle.
- First cycle after reset release: Y_q starts from 0, so if Y=1 at that edge, y_rise pulses.
- Glitch-free registered outputs; no handshake and no backpressure.
- Simultaneous rise on one bit and fall on another bit is allowed and reported independently per bit.

Decomposition:
- Shared package and_gate_pkg holds:
  - DEF_WIDTH = 1
  - DEF_CNT_W = 16
  - a saturating-increment function
- One natural sub-module is edge_detect:
  - parameter WIDTH
  - inputs clk, rst_n, d
  - outputs q, rise, fall
- It is instantiated once to produce Y_q, y_rise and y_fall.
- Combinational AND and hi_cnt live in the top level.

Test Plan:
- Combinational truth table, WIDTH=1, clock idle: apply A,B = 00, 10, 01, 11 at 5-unit spacing -> Y = 0, 0, 0, 1, settling within the same timestep.
- Reset: drive A=B=1 for 3 cycles, then assert rst_n=0 for 1 edge -> Y_q=0, y_rise=0, y_fall=0, hi_cnt=0 after that edge, while Y remains 1 throughout.
- Edges: from reset, A=1, B toggles 0,1,1,0 on successive edges -> Y_q = 0,1,1,0; y_rise pulses only on the 2nd edge; y_fall pulses only on the 4th edge.
- Counter: A=B=1 held for 10 cycles after reset release -> hi_cnt=10. Then B=0 for 5 cycles -> hi_cnt stays 10.
- Saturation: CNT_W=3, A=B=1 for 12 cycles -> hi_cnt climbs to 7 and stays 7, with no wrap.
- Multi-bit: WIDTH=4, A=4'b1100, B=4'b1010 -> Y=4'b1000. Next A=4'b0110 -> Y=4'b0010; on that edge y_rise=4'b0010 and y_fall=4'b1000 simultaneously.
